// File: rtl/crank_wheel_gen.sv
// Crank tooth-wheel emulator: N-minus-M tooth train with double-buffered geometry applied at revolution start.
// Outputs registered, first tooth one cycle after enable; no backpressure, free-running while ena is high.
module crank_wheel_gen #(
  parameter int PW = 24,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          load,
  input  logic [PW-1:0] period,
  input  logic [PW-1:0] high_time,
  input  logic [TW-1:0] teeth_total,
  input  logic [TW-1:0] teeth_missing,
  output logic          tooth_out,
  output logic          tooth_edge,
  output logic          rev_pulse,
  output logic [TW-1:0] tooth_idx,
  output logic          gap_active,
  output logic          busy,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, HI, LO, GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] act_period, act_high, sh_period, sh_high;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] act_total, act_missing, sh_total, sh_missing;
  logic [TW-1:0] gcnt_q, gcnt_d, idx_d, n_real;
  logic          pending, edge_d, rev_d, take_in, take_sh, rev_start, sh_load;
  logic          in_ok, sh_ok;

  function automatic logic cfg_ok(input logic [PW-1:0] p, input logic [PW-1:0] h,
                                  input logic [TW-1:0] t, input logic [TW-1:0] m);
    return (p >= PW'(2)) && (h != '0) && (h < p) && (t >= TW'(3)) && (m <= t - TW'(2));
  endfunction

  assign in_ok   = cfg_ok(period, high_time, teeth_total, teeth_missing);
  assign sh_ok   = cfg_ok(sh_period, sh_high, sh_total, sh_missing);
  assign n_real  = act_total - act_missing;
  assign sh_load = load && (state_q != IDLE) && ena;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    idx_d     = tooth_idx;
    edge_d    = 1'b0;
    rev_d     = 1'b0;
    take_in   = 1'b0;
    take_sh   = 1'b0;
    rev_start = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        gcnt_d = '0;
        idx_d  = '0;
        // A load in IDLE wins over starting so the new config is what runs.
        if (load) begin
          take_in = 1'b1;
        end else if (ena && !cfg_err) begin
          state_d = HI;
          edge_d  = 1'b1;
          rev_d   = 1'b1;
        end
      end
      HI: begin
        cnt_d = cnt_q + PW'(1);
        if (cnt_q == act_high - PW'(1)) state_d = LO;
      end
      LO: begin
        cnt_d = cnt_q + PW'(1);
        if (cnt_q == act_period - PW'(1)) begin
          cnt_d = '0;
          if (tooth_idx < n_real - TW'(1)) begin
            state_d = HI;
            idx_d   = tooth_idx + TW'(1);
            edge_d  = 1'b1;
          end else if (act_missing != '0) begin
            state_d = GAP;
            gcnt_d  = '0;
          end else begin
            rev_start = 1'b1;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + PW'(1);
        if (cnt_q == act_period - PW'(1)) begin
          cnt_d  = '0;
          gcnt_d = gcnt_q + TW'(1);
          if (gcnt_q == act_missing - TW'(1)) rev_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rev_start) begin
      idx_d  = '0;
      gcnt_d = '0;
      take_sh = pending;
      // An invalid pending config stops the wheel before tooth 0 is drawn.
      if (pending && !sh_ok) begin
        state_d = IDLE;
      end else begin
        state_d = HI;
        edge_d  = 1'b1;
        rev_d   = 1'b1;
      end
    end

    if (state_q != IDLE && !ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      gcnt_d  = '0;
      idx_d   = '0;
      edge_d  = 1'b0;
      rev_d   = 1'b0;
      take_in = load;
      take_sh = pending && !load;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      tooth_idx   <= '0;
      tooth_out   <= 1'b0;
      tooth_edge  <= 1'b0;
      rev_pulse   <= 1'b0;
      gap_active  <= 1'b0;
      busy        <= 1'b0;
      cfg_err     <= 1'b1;
      pending     <= 1'b0;
      act_period  <= '0;
      act_high    <= '0;
      act_total   <= '0;
      act_missing <= '0;
      sh_period   <= '0;
      sh_high     <= '0;
      sh_total    <= '0;
      sh_missing  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      tooth_idx  <= idx_d;
      tooth_out  <= (state_d == HI);
      tooth_edge <= edge_d;
      rev_pulse  <= rev_d;
      gap_active <= (state_d == GAP);
      busy       <= (state_d != IDLE);

      if (take_in) begin
        act_period  <= period;
        act_high    <= high_time;
        act_total   <= teeth_total;
        act_missing <= teeth_missing;
        cfg_err     <= !in_ok;
      end else if (take_sh) begin
        act_period  <= sh_period;
        act_high    <= sh_high;
        act_total   <= sh_total;
        act_missing <= sh_missing;
        cfg_err     <= !sh_ok;
      end

      if (sh_load) begin
        sh_period  <= period;
        sh_high    <= high_time;
        sh_total   <= teeth_total;
        sh_missing <= teeth_missing;
        pending    <= 1'b1;
      end else if (take_in || take_sh) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Directed bench for crank_wheel_gen: table-driven tooth-train checks plus hand-written stop/restart sequences.
module tb_crank_wheel_gen;

  localparam int PW = 24;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] period = '0;
  logic [PW-1:0] high_time = '0;
  logic [TW-1:0] teeth_total = '0;
  logic [TW-1:0] teeth_missing = '0;
  logic          tooth_out, tooth_edge, rev_pulse, gap_active, busy, cfg_err;
  logic [TW-1:0] tooth_idx;

  crank_wheel_gen #(.PW(PW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .load(load),
    .period(period), .high_time(high_time), .teeth_total(teeth_total), .teeth_missing(teeth_missing),
    .tooth_out(tooth_out), .tooth_edge(tooth_edge), .rev_pulse(rev_pulse), .tooth_idx(tooth_idx),
    .gap_active(gap_active), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic     to;
    logic     te;
    logic     rp;
    logic     ga;
    logic [7:0] idx;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {tooth_out, tooth_edge, rev_pulse, gap_active, tooth_idx};
  endfunction

  task automatic add(input int c, input logic to, input logic te, input logic rp, input logic ga,
                     input logic [7:0] idx);
    vec_t v;
    v.cyc = c; v.to = to; v.te = te; v.rp = rp; v.ga = ga; v.idx = idx;
    tbl.push_back(v);
  endtask

  // Walks the table in cycle order, comparing {tooth_out,edge,rev,gap,idx} at each listed cycle.
  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc && cyc < 5000) tick();
      if (cyc != tbl[i].cyc) begin
        check({name, "_reach"}, 32'(cyc), 32'(tbl[i].cyc));
      end else begin
        check(name, 32'(obs()), 32'({tbl[i].to, tbl[i].te, tbl[i].rp, tbl[i].ga, tbl[i].idx}));
      end
    end
    tbl.delete();
  endtask

  // Reset, load a config in IDLE, then raise ena in what is numbered cycle 0.
  task automatic restart(input int p, input int h, input int t, input int m);
    rst = 1'b0; ena = 1'b0; load = 1'b0;
    tick();
    rst = 1'b1;
    period = PW'(p); high_time = PW'(h); teeth_total = TW'(t); teeth_missing = TW'(m);
    load = 1'b1;
    tick();
    load = 1'b0;
    cyc = 0;
    ena = 1'b1;
  endtask

  int to_hi, ga_hi, rp_hi, busy_hi;

  task automatic count_run(input int n);
    to_hi = 0; ga_hi = 0; rp_hi = 0; busy_hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      to_hi += int'(tooth_out);
      ga_hi += int'(gap_active);
      rp_hi += int'(rev_pulse);
      busy_hi += int'(busy);
    end
  endtask

  initial begin
    // 1) reset held with ena high, then an invalid (cleared) config keeps the wheel quiet
    rst = 1'b0; ena = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 32'({obs(), busy, cfg_err}), 32'({12'h000, 1'b0, 1'b1}));
    rst = 1'b1;
    count_run(100);
    check("reset_no_tooth", 32'(to_hi), 32'(0));
    check("reset_not_busy", 32'(busy_hi), 32'(0));
    check("reset_cfg_err", 32'(cfg_err), 32'(1));

    // 2) 10/4/6/2 basic train with gap
    restart(10, 4, 6, 2);
    add(1, 1, 1, 1, 0, 0);  add(2, 1, 0, 0, 0, 0);  add(4, 1, 0, 0, 0, 0);
    add(5, 0, 0, 0, 0, 0);  add(10, 0, 0, 0, 0, 0); add(11, 1, 1, 0, 0, 1);
    add(21, 1, 1, 0, 0, 2); add(31, 1, 1, 0, 0, 3); add(35, 0, 0, 0, 0, 3);
    add(40, 0, 0, 0, 0, 3); add(41, 0, 0, 0, 1, 3); add(51, 0, 0, 0, 1, 3);
    add(60, 0, 0, 0, 1, 3); add(61, 1, 1, 1, 0, 0); add(71, 1, 1, 0, 0, 1);
    run_table("basic");

    // 3) period changed mid-revolution takes effect only at the next tooth 0
    restart(10, 4, 6, 2);
    while (cyc < 15) tick();
    period = PW'(20); load = 1'b1;
    tick();
    load = 1'b0;
    add(21, 1, 1, 0, 0, 2); add(31, 1, 1, 0, 0, 3); add(41, 0, 0, 0, 1, 3);
    add(61, 1, 1, 1, 0, 0); add(71, 0, 0, 0, 0, 0); add(80, 0, 0, 0, 0, 0);
    add(81, 1, 1, 0, 0, 1); add(101, 1, 1, 0, 0, 2); add(121, 1, 1, 0, 0, 3);
    add(141, 0, 0, 0, 1, 3); add(180, 0, 0, 0, 1, 3); add(181, 1, 1, 1, 0, 0);
    run_table("shadow");

    // 4) high_time == period is rejected; a valid load clears the error and starts
    rst = 1'b0; ena = 1'b0; load = 1'b0;
    tick();
    rst = 1'b1;
    period = PW'(10); high_time = PW'(10); teeth_total = TW'(6); teeth_missing = TW'(2);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("bad_cfg_err", 32'(cfg_err), 32'(1));
    ena = 1'b1;
    count_run(20);
    check("bad_cfg_no_tooth", 32'(to_hi), 32'(0));
    high_time = PW'(4); load = 1'b1;
    tick();
    load = 1'b0;
    check("good_cfg_clear", 32'({cfg_err, tooth_out}), 32'({1'b0, 1'b0}));
    tick();
    check("good_cfg_start", 32'(obs()), 32'({4'b1110, 8'd0}));

    // 5) enable dropped inside tooth 3, restart begins at tooth 0
    restart(10, 4, 6, 2);
    while (cyc < 33) tick();
    check("stop_pre", 32'(obs()), 32'({4'b1000, 8'd3}));
    ena = 1'b0;
    tick();
    check("stop_idle", 32'({obs(), busy}), 32'({12'h000, 1'b0}));
    while (cyc < 40) tick();
    check("stop_quiet", 32'(tooth_out), 32'(0));
    ena = 1'b1;
    tick();
    check("restart_tooth0", 32'({obs(), busy}), 32'({4'b1110, 8'd0, 1'b1}));

    // 6) no missing teeth: uniform 5-clock pitch, revolution every 20
    restart(5, 2, 4, 0);
    add(1, 1, 1, 1, 0, 0);  add(3, 0, 0, 0, 0, 0);  add(6, 1, 1, 0, 0, 1);
    add(11, 1, 1, 0, 0, 2); add(16, 1, 1, 0, 0, 3); add(20, 0, 0, 0, 0, 3);
    add(21, 1, 1, 1, 0, 0); add(41, 1, 1, 1, 0, 0);
    run_table("uniform");
    count_run(60);
    check("uniform_no_gap", 32'(ga_hi), 32'(0));
    check("uniform_rev_count", 32'(rp_hi), 32'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
